// File: rtl/tut9_xcel_mem_responder.sv
// Single-outstanding 16B memory responder for accelerator unit tests.
// Holds p_num_lines byte-writable 128-bit lines and answers each request
// after a programmable latency of p_latency extra cycles.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   mem_reqstream_msg/val/rdy       incoming mem_req_16B_t request stream
//   mem_respstream_msg/val/rdy      outgoing mem_resp_16B_t response stream

package tut9_xcel_mem_responder_pkg;
    localparam int unsigned TYPE_W   = 3;
    localparam int unsigned OPAQUE_W = 8;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned DATA_W   = 128;
    localparam int unsigned TEST_W   = 2;
    localparam int unsigned REQ_W    = TYPE_W + OPAQUE_W + ADDR_W + LEN_W + DATA_W;
    localparam int unsigned RESP_W   = TYPE_W + OPAQUE_W + TEST_W + LEN_W + DATA_W;

    localparam logic [TYPE_W-1:0] MEM_READ       = 3'd0;
    localparam logic [TYPE_W-1:0] MEM_WRITE      = 3'd1;
    localparam logic [TYPE_W-1:0] MEM_WRITE_INIT = 3'd2;

    typedef struct packed {
        logic [TYPE_W-1:0]   type_;
        logic [OPAQUE_W-1:0] opaque;
        logic [ADDR_W-1:0]   addr;
        logic [LEN_W-1:0]    len;
        logic [DATA_W-1:0]   data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [TYPE_W-1:0]   type_;
        logic [OPAQUE_W-1:0] opaque;
        logic [TEST_W-1:0]   test;
        logic [LEN_W-1:0]    len;
        logic [DATA_W-1:0]   data;
    } mem_resp_16B_t;
endpackage

module tut9_xcel_mem_responder
    import tut9_xcel_mem_responder_pkg::*;
#(
    parameter int unsigned p_num_lines = 256,
    parameter int unsigned p_latency   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQ_W-1:0]  mem_reqstream_msg,
    input  logic              mem_reqstream_val,
    output logic              mem_reqstream_rdy,
    output logic [RESP_W-1:0] mem_respstream_msg,
    output logic              mem_respstream_val,
    input  logic              mem_respstream_rdy
);
    localparam int unsigned IDX_W = $clog2(p_num_lines);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // State entered on acceptance depends only on the configured latency
    localparam logic [1:0] FIRST_STATE = (p_latency == 0) ? RESP : WAIT;
    localparam logic [3:0] FIRST_CNT   = 4'(p_latency);

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    mem_req_16B_t        req;
    mem_resp_16B_t       resp_q, resp_d;
    logic                xfer;

    logic [DATA_W-1:0]   mem [p_num_lines];
    logic [IDX_W-1:0]    idx;
    logic [3:0]          off;
    logic [4:0]          nbytes;
    logic [15:0]         nmask, wmask;
    logic [6:0]          bit_sh;
    logic [DATA_W-1:0]   line_old, line_new, wdata_sh, rdata_sh, rdata;
    logic                err_range, err_bounds, err_type, err;
    logic                is_write, is_read;

    assign req = mem_req_16B_t'(mem_reqstream_msg);

    // Address decode and error classification
    assign idx        = req.addr[4 +: IDX_W];
    assign off        = req.addr[3:0];
    assign nbytes     = (req.len == '0) ? 5'd16 : {1'b0, req.len};
    assign err_range  = |(req.addr >> (4 + IDX_W));
    assign err_bounds = ({1'b0, off} + nbytes) > 5'd16;
    assign err_type   = (req.type_ != MEM_READ) && (req.type_ != MEM_WRITE)
                        && (req.type_ != MEM_WRITE_INIT);
    assign err        = err_range || err_bounds || err_type;
    assign is_write   = !err && ((req.type_ == MEM_WRITE) || (req.type_ == MEM_WRITE_INIT));
    assign is_read    = !err && (req.type_ == MEM_READ);

    // Byte masks: nmask covers the n low bytes, wmask the same bytes at the offset
    assign nmask    = 16'((17'd1 << nbytes) - 17'd1);
    assign wmask    = nmask << off;
    assign bit_sh   = {off, 3'b000};
    assign line_old = mem[idx];
    assign wdata_sh = req.data << bit_sh;
    assign rdata_sh = line_old >> bit_sh;

    // Byte merge for writes and right-justified extraction for reads
    always_comb begin
        line_new = line_old;
        rdata    = '0;
        for (int i = 0; i < 16; i++) begin
            if (wmask[i]) line_new[8*i +: 8] = wdata_sh[8*i +: 8];
            if (nmask[i]) rdata[8*i +: 8]    = rdata_sh[8*i +: 8];
        end
    end

    assign xfer = mem_reqstream_val && mem_reqstream_rdy;

    // Line storage; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (xfer && is_write) mem[idx] <= line_new;
    end

    // Response payload captured at acceptance
    always_comb begin
        resp_d        = '0;
        resp_d.type_  = req.type_;
        resp_d.opaque = req.opaque;
        resp_d.test   = {1'b0, err};
        resp_d.len    = req.len;
        resp_d.data   = is_read ? rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     resp_q <= '0;
        else if (xfer) resp_q <= resp_d;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = FIRST_STATE;
                    cnt_d   = FIRST_CNT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                if (mem_respstream_rdy) begin
                    if (xfer) begin
                        state_d = FIRST_STATE;
                        cnt_d   = FIRST_CNT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In RESP a new request may enter only as the current response leaves
    assign mem_reqstream_rdy  = !reset && ((state_q == IDLE)
                                || ((state_q == RESP) && mem_respstream_rdy));
    assign mem_respstream_val = (state_q == RESP);
    assign mem_respstream_msg = mem_respstream_val ? RESP_W'(resp_q) : '0;

endmodule

// File: tb/tb_tut9_xcel_mem_responder.sv
// Bench for tut9_xcel_mem_responder: one instance with zero latency and one
// with latency 3, checked against a byte-array reference model.
module tb_tut9_xcel_mem_responder;
    import tut9_xcel_mem_responder_pkg::*;

    localparam int unsigned NL = 256;

    logic              clk = 1'b0;
    logic [1:0]        rst;
    logic [REQ_W-1:0]  req_msg [2];
    logic [1:0]        req_val;
    logic [1:0]        req_rdy;
    logic [RESP_W-1:0] resp_msg [2];
    logic [1:0]        resp_val;
    logic [1:0]        resp_rdy;

    logic [7:0]        ref_mem [2][NL*16];
    int                cyc = 0;
    int                vectors = 0;
    int                miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tut9_xcel_mem_responder #(.p_num_lines(NL), .p_latency(0)) u_lat0 (
        .clk(clk), .reset(rst[0]),
        .mem_reqstream_msg(req_msg[0]), .mem_reqstream_val(req_val[0]),
        .mem_reqstream_rdy(req_rdy[0]),
        .mem_respstream_msg(resp_msg[0]), .mem_respstream_val(resp_val[0]),
        .mem_respstream_rdy(resp_rdy[0])
    );

    tut9_xcel_mem_responder #(.p_num_lines(NL), .p_latency(3)) u_lat3 (
        .clk(clk), .reset(rst[1]),
        .mem_reqstream_msg(req_msg[1]), .mem_reqstream_val(req_val[1]),
        .mem_reqstream_rdy(req_rdy[1]),
        .mem_respstream_msg(resp_msg[1]), .mem_respstream_val(resp_val[1]),
        .mem_respstream_rdy(resp_rdy[1])
    );

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed no handshake in 64 cycles, expected handshake", tag);
    endtask

    function automatic int lat(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic mem_req_16B_t mk_req(logic [2:0] t, logic [7:0] op,
                                            logic [31:0] a, logic [3:0] l,
                                            logic [127:0] d);
        mem_req_16B_t r;
        r.type_  = t;
        r.opaque = op;
        r.addr   = a;
        r.len    = l;
        r.data   = d;
        return r;
    endfunction

    // Reference model: flat byte array per instance, applied at acceptance
    function automatic mem_resp_16B_t model(int k, mem_req_16B_t r);
        mem_resp_16B_t p;
        int            n;
        int            off;
        longint        line;
        bit            err;
        n    = (r.len == 4'd0) ? 16 : int'(r.len);
        off  = int'(r.addr[3:0]);
        line = longint'(r.addr >> 4);
        err  = (line >= longint'(NL)) || (off + n > 16) || (r.type_ > MEM_WRITE_INIT);
        p        = '0;
        p.type_  = r.type_;
        p.opaque = r.opaque;
        p.len    = r.len;
        p.test   = err ? 2'd1 : 2'd0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (r.type_ == MEM_READ) p.data[8*i +: 8] = ref_mem[k][int'(line)*16 + off + i];
                else ref_mem[k][int'(line)*16 + off + i] = r.data[8*i +: 8];
            end
        end
        return p;
    endfunction

    task automatic send(int k, mem_req_16B_t r, output int t_acc);
        int guard = 0;
        @(negedge clk);
        req_msg[k] = REQ_W'(r);
        req_val[k] = 1'b1;
        while (!req_rdy[k] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!req_rdy[k]) timeout("send");
        t_acc = cyc;
        @(posedge clk);
        #1;
        req_val[k] = 1'b0;
        req_msg[k] = '0;
    endtask

    task automatic recv(int k, output mem_resp_16B_t p, output int t_val);
        int guard = 0;
        @(negedge clk);
        while (!resp_val[k] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!resp_val[k]) timeout("recv");
        p     = mem_resp_16B_t'(resp_msg[k]);
        t_val = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic xact(int k, mem_req_16B_t r, string tag, output mem_resp_16B_t p);
        mem_resp_16B_t e;
        int            ta;
        int            tv;
        e = model(k, r);
        send(k, r, ta);
        recv(k, p, tv);
        check({tag, "_msg"}, 256'(p), 256'(e));
        check({tag, "_lat"}, 256'(tv - ta), 256'(1 + lat(k)));
    endtask

    initial begin
        mem_resp_16B_t p;
        mem_resp_16B_t pb;
        mem_resp_16B_t ea;
        mem_resp_16B_t eb;
        mem_resp_16B_t exq [8];
        mem_req_16B_t  r;
        mem_req_16B_t  rb;
        int            ta;
        int            tb_acc;
        int            tv;
        int            guard;

        rst        = 2'b11;
        req_val    = 2'b00;
        resp_rdy   = 2'b11;
        req_msg[0] = '0;
        req_msg[1] = '0;

        // Reset values
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_rdy", 256'(req_rdy[k]), 256'(0));
            check("reset_val", 256'(resp_val[k]), 256'(0));
            check("reset_msg", 256'(resp_msg[k]), 256'(0));
        end
        rst = 2'b00;
        #1;
        for (int k = 0; k < 2; k++) check("post_reset_rdy", 256'(req_rdy[k]), 256'(1));

        // Initialise every line of both instances
        for (int k = 0; k < 2; k++) begin
            for (int line = 0; line < int'(NL); line++) begin
                xact(k, mk_req(MEM_WRITE_INIT, 8'(line), 32'(line) << 4, 4'd0, rand128()),
                     "init", p);
            end
        end

        // Write then read
        xact(0, mk_req(MEM_WRITE_INIT, 8'h11, 32'h0000_0010, 4'd4, 128'hDEADBEEF), "wi", p);
        check("wi_type", 256'(p.type_), 256'(MEM_WRITE_INIT));
        check("wi_data", 256'(p.data), 256'(0));
        check("wi_test", 256'(p.test), 256'(0));
        xact(0, mk_req(MEM_READ, 8'h12, 32'h0000_0010, 4'd4, 128'h0), "rd", p);
        check("rd_data", 256'(p.data), 256'(128'hDEADBEEF));
        check("rd_opaque", 256'(p.opaque), 256'(8'h12));

        // Byte and line granularity
        xact(0, mk_req(MEM_WRITE, 8'h20, 32'h20, 4'd0, 128'h0F0E0D0C0B0A09080706050403020100),
             "wline", p);
        xact(0, mk_req(MEM_READ, 8'h21, 32'h25, 4'd2, 128'h0), "rd25", p);
        check("rd25_data", 256'(p.data), 256'(16'h0605));
        xact(0, mk_req(MEM_WRITE, 8'h22, 32'h22, 4'd1, 128'hAA), "wbyte", p);
        xact(0, mk_req(MEM_READ, 8'h23, 32'h20, 4'd4, 128'h0), "rd20", p);
        check("rd20_data", 256'(p.data), 256'(32'h03AA0100));

        // Error requests
        xact(0, mk_req(MEM_READ, 8'h30, 32'h0000_1000, 4'd4, 128'h0), "err_range", p);
        check("err_range_test", 256'(p.test), 256'(1));
        check("err_range_data", 256'(p.data), 256'(0));
        xact(0, mk_req(MEM_READ, 8'h31, 32'h0000_000C, 4'd8, 128'h0), "err_span", p);
        check("err_span_test", 256'(p.test), 256'(1));
        check("err_span_data", 256'(p.data), 256'(0));
        xact(0, mk_req(MEM_READ, 8'h32, 32'h0, 4'd0, 128'h0), "line0_before", ea);
        xact(0, mk_req(MEM_WRITE, 8'h33, 32'h0000_2000, 4'd0, rand128()), "err_wr", p);
        check("err_wr_test", 256'(p.test), 256'(1));
        xact(0, mk_req(MEM_READ, 8'h34, 32'h0, 4'd0, 128'h0), "line0_after", p);
        check("line0_unchanged", 256'(p.data), 256'(ea.data));
        xact(0, mk_req(3'd5, 8'h35, 32'h40, 4'd4, 128'h0), "err_type", p);
        check("err_type_test", 256'(p.test), 256'(1));

        // Streaming at zero latency, sink always ready
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                int o;
                int n;
                o = int'($urandom_range(0, 15));
                n = int'($urandom_range(1, 16 - o));
                r = mk_req(MEM_READ, 8'(i), (32'($urandom_range(0, NL - 1)) << 4) | 32'(o),
                           4'(n), 128'h0);
                exq[i]     = model(0, r);
                req_msg[0] = REQ_W'(r);
                req_val[0] = 1'b1;
                check("stream_rdy", 256'(req_rdy[0]), 256'(1));
            end else begin
                req_val[0] = 1'b0;
                req_msg[0] = '0;
            end
            if (i >= 1) begin
                check("stream_val", 256'(resp_val[0]), 256'(1));
                check("stream_msg", 256'(resp_msg[0]), 256'(exq[i-1]));
            end
        end

        // Latency 3 with back-pressure
        r  = mk_req(MEM_READ, 8'h5A, 32'($urandom_range(0, NL - 1)) << 4, 4'd0, 128'h0);
        ea = model(1, r);
        resp_rdy[1] = 1'b0;
        send(1, r, ta);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("bp_val", 256'(resp_val[1]), 256'(c >= 4));
            check("bp_req_rdy", 256'(req_rdy[1]), 256'(0));
            if (c >= 4) check("bp_msg", 256'(resp_msg[1]), 256'(ea));
        end
        resp_rdy[1] = 1'b1;
        #1;
        check("bp_rdy_follows", 256'(req_rdy[1]), 256'(1));
        @(negedge clk);
        check("bp_done_val", 256'(resp_val[1]), 256'(0));
        check("bp_done_rdy", 256'(req_rdy[1]), 256'(1));

        // New request accepted in the response handshake cycle
        r  = mk_req(MEM_READ, 8'hA1, 32'h0000_0050, 4'd0, 128'h0);
        rb = mk_req(MEM_READ, 8'hA2, 32'h0000_0064, 4'd4, 128'h0);
        ea = model(1, r);
        eb = model(1, rb);
        send(1, r, ta);
        guard = 0;
        @(negedge clk);
        while (!resp_val[1] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!resp_val[1]) timeout("b2b_wait");
        check("b2b_a_msg", 256'(resp_msg[1]), 256'(ea));
        req_msg[1] = REQ_W'(rb);
        req_val[1] = 1'b1;
        #1;
        check("b2b_rdy", 256'(req_rdy[1]), 256'(1));
        tb_acc = cyc;
        @(posedge clk);
        #1;
        req_val[1] = 1'b0;
        req_msg[1] = '0;
        recv(1, pb, tv);
        check("b2b_b_msg", 256'(pb), 256'(eb));
        check("b2b_b_lat", 256'(tv - tb_acc), 256'(4));

        // Randomised traffic on both instances
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 150; j++) begin
                int          sel;
                logic [2:0]  t;
                logic [31:0] a;
                sel = int'($urandom_range(0, 9));
                if (sel <= 3)      t = MEM_READ;
                else if (sel <= 6) t = MEM_WRITE;
                else if (sel <= 8) t = MEM_WRITE_INIT;
                else               t = 3'($urandom_range(3, 7));
                a = (32'($urandom_range(0, NL - 1)) << 4) | 32'($urandom_range(0, 15));
                if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(12, 31));
                xact(k, mk_req(t, 8'($urandom()), a, 4'($urandom_range(0, 15)), rand128()),
                     "rand", p);
            end
        end

        // Reset during WAIT: committed write survives
        r = mk_req(MEM_WRITE, 8'h77, 32'h0000_0300, 4'd8, rand128());
        void'(model(1, r));
        send(1, r, ta);
        @(negedge clk);
        check("rst_wait_val", 256'(resp_val[1]), 256'(0));
        rst[1] = 1'b1;
        #1;
        check("rst_rdy", 256'(req_rdy[1]), 256'(0));
        check("rst_val", 256'(resp_val[1]), 256'(0));
        check("rst_msg", 256'(resp_msg[1]), 256'(0));
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        check("rst_rdy_after", 256'(req_rdy[1]), 256'(1));
        xact(1, mk_req(MEM_READ, 8'h78, 32'h0000_0300, 4'd8, 128'h0), "rst_read", p);

        // Reset while a response is pending
        resp_rdy[1] = 1'b0;
        send(1, mk_req(MEM_READ, 8'h79, 32'h0000_0310, 4'd0, 128'h0), ta);
        guard = 0;
        @(negedge clk);
        while (!resp_val[1] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("rst_resp_pending", 256'(resp_val[1]), 256'(1));
        rst[1] = 1'b1;
        #1;
        check("rst_resp_val", 256'(resp_val[1]), 256'(0));
        check("rst_resp_msg", 256'(resp_msg[1]), 256'(0));
        @(negedge clk);
        rst[1]      = 1'b0;
        resp_rdy[1] = 1'b1;
        xact(1, mk_req(MEM_READ, 8'h7A, 32'h0000_0310, 4'd0, 128'h0), "rst_next", p);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
